// File: rtl/mold_feed_arb.sv
// MoldUDP64 N-way feed arbiter: session/sequence tracking, keep/drop verdict, skip count, gap/EOS/flatline.
// Latency: verdict, gap and pulse outputs are registered, one cycle after hdr_v_i; flatline follows its counter.
// Backpressure: none; every header pulse is evaluated in its own cycle and is never stalled.
module mold_feed_arb #(
    parameter int                FEED_N       = 2,
    parameter int                SID_W        = 80,
    parameter int                SEQ_NUM_W    = 64,
    parameter int                ML_W         = 16,
    parameter logic [ML_W-1:0]   EOS_MSG_CNT  = '1,
    parameter int                FLATLINE_CYC = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FEED_N-1:0]             hdr_v_i,
    input  logic [FEED_N*SID_W-1:0]       hdr_sid_i,
    input  logic [FEED_N*SEQ_NUM_W-1:0]   hdr_seq_i,
    input  logic [FEED_N*ML_W-1:0]        hdr_cnt_i,
    output logic [FEED_N-1:0]             pkt_v_o,
    output logic [FEED_N-1:0]             pkt_keep_o,
    output logic [FEED_N*ML_W-1:0]        pkt_skip_o,
    output logic [FEED_N-1:0]             gap_v_o,
    output logic [FEED_N*SEQ_NUM_W-1:0]   gap_start_o,
    output logic [FEED_N*SEQ_NUM_W-1:0]   gap_cnt_o,
    output logic                          sid_chg_v_o,
    output logic                          eos_v_o,
    output logic [SEQ_NUM_W-1:0]          exp_seq_o,
    output logic [FEED_N-1:0]             flatlined_o
);

    localparam int FL_W = $clog2(FLATLINE_CYC + 1);

    // ST_EOS is INIT entered via end of session: the finished session id may not be re-adopted.
    typedef enum logic [1:0] {ST_INIT, ST_SYNC, ST_EOS} state_t;

    state_t                 st;
    logic [SID_W-1:0]       exp_sid;
    logic [SEQ_NUM_W-1:0]   exp_seq;

    state_t                 nxt_st;
    logic [SID_W-1:0]       nxt_sid;
    logic [SEQ_NUM_W-1:0]   nxt_seq;
    logic                   sid_chg_c;
    logic                   eos_c;
    logic [FEED_N-1:0]      keep_c;
    logic [FEED_N-1:0]      gap_v_c;
    logic [ML_W-1:0]        skip_c      [FEED_N];
    logic [SEQ_NUM_W-1:0]   gap_start_c [FEED_N];
    logic [SEQ_NUM_W-1:0]   gap_cnt_c   [FEED_N];

    logic [SID_W-1:0]       sid_f;
    logic [SEQ_NUM_W-1:0]   seq_f;
    logic [ML_W-1:0]        cnt_f;
    logic [SEQ_NUM_W:0]     end_f;

    logic [FL_W-1:0]        fl_cnt [FEED_N];

    // Feed-ordered evaluation chain: each feed sees the session state left by lower-indexed feeds.
    always_comb begin
        nxt_st    = st;
        nxt_sid   = exp_sid;
        nxt_seq   = exp_seq;
        sid_chg_c = 1'b0;
        eos_c     = 1'b0;
        keep_c    = '0;
        gap_v_c   = '0;
        sid_f     = '0;
        seq_f     = '0;
        cnt_f     = '0;
        end_f     = '0;
        for (int f = 0; f < FEED_N; f++) begin
            skip_c[f]      = '0;
            gap_start_c[f] = '0;
            gap_cnt_c[f]   = '0;
            sid_f = hdr_sid_i[f*SID_W +: SID_W];
            seq_f = hdr_seq_i[f*SEQ_NUM_W +: SEQ_NUM_W];
            cnt_f = hdr_cnt_i[f*ML_W +: ML_W];
            end_f = {1'b0, seq_f} + (SEQ_NUM_W+1)'(cnt_f);
            if (hdr_v_i[f]) begin
                if (nxt_st == ST_SYNC && sid_f == nxt_sid) begin
                    if (cnt_f == '0 || cnt_f == EOS_MSG_CNT) begin
                        // Heartbeat or end of session: no payload, but may still expose a gap.
                        if (seq_f > nxt_seq) begin
                            gap_v_c[f]     = 1'b1;
                            gap_start_c[f] = nxt_seq;
                            gap_cnt_c[f]   = seq_f - nxt_seq;
                            nxt_seq        = seq_f;
                        end
                        if (cnt_f == EOS_MSG_CNT) begin
                            eos_c  = 1'b1;
                            nxt_st = ST_EOS;
                        end
                    end else if (end_f <= {1'b0, nxt_seq}) begin
                        // Pure duplicate: everything already forwarded.
                        keep_c[f] = 1'b0;
                    end else if (seq_f <= nxt_seq) begin
                        // Overlap: forward only the unseen tail.
                        keep_c[f] = 1'b1;
                        skip_c[f] = ML_W'(nxt_seq - seq_f);
                        nxt_seq   = end_f[SEQ_NUM_W-1:0];
                    end else begin
                        keep_c[f]      = 1'b1;
                        gap_v_c[f]     = 1'b1;
                        gap_start_c[f] = nxt_seq;
                        gap_cnt_c[f]   = seq_f - nxt_seq;
                        nxt_seq        = end_f[SEQ_NUM_W-1:0];
                    end
                end else if ((nxt_st == ST_INIT || sid_f > nxt_sid) && cnt_f != EOS_MSG_CNT) begin
                    // Adopt a new session starting at this packet.
                    keep_c[f] = 1'b1;
                    nxt_sid   = sid_f;
                    nxt_seq   = end_f[SEQ_NUM_W-1:0];
                    nxt_st    = ST_SYNC;
                    sid_chg_c = 1'b1;
                end
            end
        end
    end

    // Register session state and all verdict/gap/pulse outputs; reset wins over any header.
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= ST_INIT;
            exp_sid     <= '0;
            exp_seq     <= '0;
            pkt_v_o     <= '0;
            pkt_keep_o  <= '0;
            pkt_skip_o  <= '0;
            gap_v_o     <= '0;
            gap_start_o <= '0;
            gap_cnt_o   <= '0;
            sid_chg_v_o <= 1'b0;
            eos_v_o     <= 1'b0;
        end else begin
            st          <= nxt_st;
            exp_sid     <= nxt_sid;
            exp_seq     <= nxt_seq;
            pkt_v_o     <= hdr_v_i;
            pkt_keep_o  <= keep_c;
            gap_v_o     <= gap_v_c;
            sid_chg_v_o <= sid_chg_c;
            eos_v_o     <= eos_c;
            for (int f = 0; f < FEED_N; f++) begin
                pkt_skip_o[f*ML_W +: ML_W]           <= skip_c[f];
                gap_start_o[f*SEQ_NUM_W +: SEQ_NUM_W] <= gap_start_c[f];
                gap_cnt_o[f*SEQ_NUM_W +: SEQ_NUM_W]   <= gap_cnt_c[f];
            end
        end
    end

    // Per-feed idle counters: clear on a header, saturate at the flatline threshold.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FEED_N; f++) begin
            if (reset || hdr_v_i[f]) begin
                fl_cnt[f] <= '0;
            end else if (fl_cnt[f] != FL_W'(FLATLINE_CYC)) begin
                fl_cnt[f] <= fl_cnt[f] + 1'b1;
            end
        end
    end

    // Flatline flag is a direct decode of the saturated counter.
    always_comb begin
        for (int f = 0; f < FEED_N; f++) begin
            flatlined_o[f] = (fl_cnt[f] == FL_W'(FLATLINE_CYC));
        end
    end

    assign exp_seq_o = exp_seq;

endmodule
